// File: rtl/ps2_port_scheduler_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 port scheduler.
//   ps2_state_e  - serial engine FSM states
//   CH_KBD/CH_MOUSE - channel ids (also FIFO instance index)
//   FRAME_BITS   - bits per PS/2 device-to-host frame
//   make_frame() - builds the 11-bit frame, LSB transmitted first
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } ps2_state_e;

  localparam logic CH_KBD   = 1'b0;
  localparam logic CH_MOUSE = 1'b1;

  localparam int FRAME_BITS = 11;

  // {stop, odd parity, data[7:0], start}. Odd parity is the complement of
  // the XOR of the data bits, i.e. an accumulator seeded with 1.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// ps2_byte_fifo: small byte FIFO with occupancy count and sticky overflow.
//   clk, reset_n     - clock, async active-low reset (empties the FIFO)
//   wr_data, wr_en   - write port; a write to a full FIFO is dropped
//   rd_en, rd_data   - pop the head; rd_data shows the head combinationally
//   count            - occupancy, 0..2**FIFO_BITS
//   ovf              - set on a dropped write, held until reset
module ps2_byte_fifo #(
  parameter int FIFO_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           wr_data,
  input  logic                 wr_en,
  input  logic                 rd_en,
  output logic [7:0]           rd_data,
  output logic [FIFO_BITS:0]   count,
  output logic                 ovf
);

  localparam int DEPTH = 1 << FIFO_BITS;
  localparam logic [FIFO_BITS:0] DEPTH_C = (FIFO_BITS + 1)'(DEPTH);

  logic [7:0]           mem [DEPTH];
  logic [FIFO_BITS-1:0] wr_ptr, rd_ptr;
  logic                 wr_ok, rd_ok;

  // Fullness is judged on the count before any same-cycle pop.
  assign wr_ok   = wr_en && (count < DEPTH_C);
  assign rd_ok   = rd_en && (count != '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !wr_ok) ovf <= 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_port_scheduler.sv
// ps2_port_scheduler: one PS/2 device-to-host serial engine time-shared
// between a keyboard and a mouse byte stream, round-robin per packet.
//   clk, reset_n                 - clock, async active-low reset
//   kbd_byte/kbd_strobe          - keyboard byte write
//   mouse_byte/mouse_strobe      - mouse byte write
//   ps2_kbd_clk/ps2_kbd_data     - keyboard port (idle high)
//   ps2_mouse_clk/ps2_mouse_data - mouse port (idle high)
//   busy                         - engine in LOAD/SHIFT/GAP
//   kbd_ovf/mouse_ovf            - sticky dropped-byte flags
module ps2_port_scheduler
  import ps2_pkg::*;
#(
  parameter int CLK_DIV       = 16,
  parameter int GAP_BITS      = 2,
  parameter int FIFO_BITS     = 3,
  parameter int MOUSE_PKT_LEN = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] kbd_byte,
  input  logic       kbd_strobe,
  input  logic [7:0] mouse_byte,
  input  logic       mouse_strobe,
  output logic       ps2_kbd_clk,
  output logic       ps2_kbd_data,
  output logic       ps2_mouse_clk,
  output logic       ps2_mouse_data,
  output logic       busy,
  output logic       kbd_ovf,
  output logic       mouse_ovf
);

  localparam int CW      = FIFO_BITS + 1;
  localparam int GAP_CYC = GAP_BITS * CLK_DIV;
  localparam int TMR_MAX = (GAP_CYC > CLK_DIV) ? GAP_CYC : CLK_DIV;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] BIT_END  = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] GAP_END  = TMR_W'(GAP_CYC - 1);
  localparam logic [TMR_W-1:0] HALF     = TMR_W'(CLK_DIV / 2);
  localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);
  localparam logic [CW-1:0]    PKT_LEN  = CW'(MOUSE_PKT_LEN);
  localparam logic [CW-1:0]    ONE      = CW'(1);

  logic [1:0][7:0]    wr_byte, rd_byte;
  logic [1:0]         wr_stb, pop, ovf;
  logic [1:0][CW-1:0] cnt;

  ps2_state_e            state, state_nx;
  logic                  grant, last_grant, arb_ch;
  logic                  kbd_el, mouse_el, any_el;
  logic [CW-1:0]         pkt_left;
  logic [TMR_W-1:0]      tmr;
  logic [3:0]            bit_idx;
  logic [FRAME_BITS-1:0] frame;
  logic                  act_clk, act_data;

  assign wr_byte = {mouse_byte, kbd_byte};
  assign wr_stb  = {mouse_strobe, kbd_strobe};

  // Index 0 = keyboard, 1 = mouse (matches CH_KBD/CH_MOUSE).
  for (genvar c = 0; c < 2; c++) begin : g_fifo
    ps2_byte_fifo #(.FIFO_BITS(FIFO_BITS)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_data (wr_byte[c]),
      .wr_en   (wr_stb[c]),
      .rd_en   (pop[c]),
      .rd_data (rd_byte[c]),
      .count   (cnt[c]),
      .ovf     (ovf[c])
    );
  end

  assign kbd_ovf   = ovf[CH_KBD];
  assign mouse_ovf = ovf[CH_MOUSE];

  // Mouse is only eligible with a whole packet buffered, so a granted
  // packet can always be sent back-to-back without re-arbitration.
  assign kbd_el   = cnt[CH_KBD] != '0;
  assign mouse_el = cnt[CH_MOUSE] >= PKT_LEN;
  assign any_el   = kbd_el | mouse_el;
  assign arb_ch   = (kbd_el && mouse_el) ? ~last_grant
                  : (kbd_el ? CH_KBD : CH_MOUSE);

  // ---- FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // ---- FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (any_el) state_nx = ST_LOAD;
      ST_LOAD:  state_nx = ST_SHIFT;
      ST_SHIFT: if (tmr == BIT_END && bit_idx == LAST_BIT) state_nx = ST_GAP;
      ST_GAP:   if (tmr == GAP_END) state_nx = (pkt_left == ONE) ? ST_IDLE : ST_LOAD;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs
  always_comb begin
    pop      = '0;
    busy     = 1'b0;
    act_clk  = 1'b1;
    act_data = 1'b1;
    case (state)
      ST_LOAD:  begin busy = 1'b1; pop[grant] = 1'b1; end
      ST_SHIFT: begin
        busy     = 1'b1;
        act_clk  = (tmr < HALF);
        act_data = frame[0];
      end
      ST_GAP:   busy = 1'b1;
      default:  ;
    endcase
  end

  // act_* are idle-high outside SHIFT, so the stale grant in IDLE is harmless.
  assign ps2_kbd_clk    = (grant == CH_KBD)   ? act_clk  : 1'b1;
  assign ps2_kbd_data   = (grant == CH_KBD)   ? act_data : 1'b1;
  assign ps2_mouse_clk  = (grant == CH_MOUSE) ? act_clk  : 1'b1;
  assign ps2_mouse_data = (grant == CH_MOUSE) ? act_data : 1'b1;

  // ---- Engine datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant      <= CH_KBD;
      last_grant <= CH_MOUSE;
      pkt_left   <= '0;
      frame      <= '1;
      tmr        <= '0;
      bit_idx    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (any_el) begin
          grant      <= arb_ch;
          last_grant <= arb_ch;
          pkt_left   <= (arb_ch == CH_MOUSE) ? PKT_LEN : ONE;
        end
        ST_LOAD: begin
          frame   <= make_frame(rd_byte[grant]);
          tmr     <= '0;
          bit_idx <= '0;
        end
        ST_SHIFT: begin
          // Next bit appears on frame[0] exactly when the timer wraps to 0.
          if (tmr == BIT_END) begin
            tmr     <= '0;
            frame   <= {1'b1, frame[FRAME_BITS-1:1]};
            bit_idx <= bit_idx + 4'd1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_GAP: begin
          if (tmr == GAP_END) begin
            tmr      <= '0;
            pkt_left <= pkt_left - 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
